mmio_timer_periph: RTL and testbench
====================================

Name: mmio_timer_periph

Overview:
- Memory-mapped peripheral responder on the CPU data-memory bus (Address, WriteData, MemRead, MemWrite → ReadData).
- Answers loads and stores in the 0x4000_0000–0x4000_0017 window.
- Implements a reloadable 32-bit timer with interrupt flag, an LED register, a 7-segment digit register and a free-running systick.
- Sits beside the data memory; the data memory's read mux selects this block's ReadData when sel is high.

Parameters:
- BASE_ADDR, 32'h4000_0000, base of the 6-word register window
- LED_W, 16, width of the LED register/output

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- Address  in  32  byte address from the MEM stage
- WriteData  in  32  store data
- MemRead  in  1  load strobe for the current cycle
- MemWrite  in  1  store strobe; committed at posedge clk
- ReadData  out  32  combinational read data
- sel  out  1  Address in window (Address[31:5] match and Address[4:2] ≤ 5)
- led  out  LED_W  LED register
- digits  out  12  [11:8] AN one-hot-low anode, [7:0] segment/BCD pattern
- irq  out  1  timer interrupt request, equals TCON[2]

Behaviour:
- Register map (word offset): 0x00 TH (reload), 0x04 TL (count), 0x08 TCON [0]=enable, [1]=irq enable, [2]=irq status, other bits read 0; 0x0C LED; 0x10 digits; 0x14 systick (read-only).
- Address[1:0] is ignored; only word accesses are supported.
- Reset (reset==0, asynchronous): TH=0, TL=0, TCON=0, LED=0, digits=12'hF00 (all anodes off), systick=0. Outputs follow: led=0, digits=12'hF00, irq=0.
- Reads: ReadData = selected register when MemRead & sel, else 32'h0. Zero latency, combinational. A read in the same cycle as a write to the same register returns the pre-write value.
- Writes: when MemWrite & sel, the addressed register takes WriteData at posedge clk. TCON keeps bits [2:0] only. Digits keeps [11:0]. LED keeps [LED_W-1:0]. Writes to systick are ignored. MemWrite with sel=0 has no effect.
- Systick increments every cycle after reset and wraps 0xFFFF_FFFF → 0.
- Timer, each posedge when TCON[0]=1:
  - TL != 32'hFFFF_FFFF: TL ← TL+1.
  - TL == 32'hFFFF_FFFF: TL ← TH; if TCON[1], TCON[2] ← 1.
- Timer when TCON[0]=0: TL holds. An overflow cannot occur, so TCON[2] holds.
- irq stays set until software writes TCON with bit 2 = 0. There is no auto-clear.
- Write-vs-count collisions, write to TL or TH in the same cycle as increment/overflow:
  - CPU write wins for the written register.
  - Write to TH on the overflow cycle: TL reloads from the old TH.
  - Write to TL on the overflow cycle: TL takes WriteData, no reload.
- Write to TCON on the overflow cycle: the written value wins entirely, including bit 2. Software clearing irq is never lost to a simultaneous set.
- Timer FSM is implicit, 2 states: IDLE (TCON[0]=0) and RUN (TCON[0]=1). Enable/disable takes effect from the cycle after the write commits.
- Reset deasserting mid-count: all state returns to reset values; counting resumes only after software re-enables.

Decomposition:
- Shared package mmio_pkg:
  - word-offset constants OFF_TH, OFF_TL, OFF_TCON, OFF_LED, OFF_DIGITS, OFF_SYSTICK
  - TCON bit indices TCON_EN, TCON_IE, TCON_IRQ
  - BASE_ADDR default
- One natural sub-module, timer_core: holds TH/TL/TCON and the reload/irq logic. It takes decoded write enables plus WriteData and exposes TH, TL, TCON.
- Address decode, LED/digits/systick registers and the read mux stay in the top.

Test Plan:
- Reset → led=0, digits=12'hF00, irq=0; read of 0x4000_0008 returns 0; read of 0x4000_0018 gives sel=0, ReadData=0.
- Write TH=0xFFFF_FFFD, TL=0xFFFF_FFFE, TCON=3 → TL reads FFFF_FFFF one cycle after enable. Next cycle TL=FFFF_FFFD and irq=1. Next cycle TL=FFFF_FFFE.
- irq set, then write TCON=3 → irq=0 on the following cycle, counting continues. Same write on the exact overflow cycle → irq stays 0.
- Write LED=0x1234_ABCD → led=16'hABCD. Write digits=0xFFFF_F7C0 → digits=12'h7C0.
- Read systick at cycles N and N+5 → difference 5. Write 0 to systick → value unaffected.
- Pulse reset low mid-count with TL=0x100 → TL=0 and irq=0 immediately; TL still 0 ten cycles after release.

Source files
------------

// File: rtl/mmio_pkg.sv
// Shared constants for the MMIO timer peripheral: register offsets, TCON bits, timer states.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mmio_pkg;

    localparam logic [31:0] BASE_ADDR_DEFAULT = 32'h4000_0000;

    // Word offsets (Address[4:2]) inside the register window
    localparam logic [2:0] OFF_TH      = 3'd0;
    localparam logic [2:0] OFF_TL      = 3'd1;
    localparam logic [2:0] OFF_TCON    = 3'd2;
    localparam logic [2:0] OFF_LED     = 3'd3;
    localparam logic [2:0] OFF_DIGITS  = 3'd4;
    localparam logic [2:0] OFF_SYSTICK = 3'd5;

    // TCON bit positions
    localparam int TCON_EN  = 0;
    localparam int TCON_IE  = 1;
    localparam int TCON_IRQ = 2;

    localparam logic [11:0] DIGITS_RESET = 12'hF00;

    // Timer mode, derived from TCON enable
    typedef enum logic {
        T_IDLE = 1'b0,
        T_RUN  = 1'b1
    } timer_state_t;

endpackage

// File: rtl/timer_core.sv
// Reloadable 32-bit up-counter with sticky interrupt flag (TH reload, TL count, TCON control).
// Latency: register writes and count steps take effect at the next posedge clk.
// Backpressure: none; writes are always accepted and win over same-cycle count/reload.
module timer_core
    import mmio_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        we_th,
    input  logic        we_tl,
    input  logic        we_tcon,
    input  logic [31:0] wdata,
    output logic [31:0] th,
    output logic [31:0] tl,
    output logic [2:0]  tcon
);

    timer_state_t state;
    logic [31:0]  th_nxt;
    logic [31:0]  tl_nxt;
    logic [2:0]   tcon_nxt;
    logic         ovf;

    // Timer registers; TCON[0] doubles as the RUN/IDLE state bit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            th   <= 32'h0;
            tl   <= 32'h0;
            tcon <= 3'b000;
        end else begin
            th   <= th_nxt;
            tl   <= tl_nxt;
            tcon <= tcon_nxt;
        end
    end

    // Next-state: count/reload in RUN, CPU writes override the written register
    always_comb begin
        state    = tcon[TCON_EN] ? T_RUN : T_IDLE;
        ovf      = 1'b0;
        th_nxt   = th;
        tl_nxt   = tl;
        tcon_nxt = tcon;

        case (state)
            T_RUN: begin
                if (tl == 32'hFFFF_FFFF) begin
                    ovf    = 1'b1;
                    // reload uses the current TH even if TH is written this cycle
                    tl_nxt = th;
                end else begin
                    tl_nxt = tl + 32'd1;
                end
            end
            default: begin
                tl_nxt = tl;
            end
        endcase

        if (ovf && tcon[TCON_IE]) begin
            tcon_nxt[TCON_IRQ] = 1'b1;
        end

        if (we_th) begin
            th_nxt = wdata;
        end
        if (we_tl) begin
            tl_nxt = wdata;
        end
        // a TCON write replaces all bits, so a software irq clear is never lost
        if (we_tcon) begin
            tcon_nxt = wdata[2:0];
        end
    end

endmodule

// File: rtl/mmio_timer_periph.sv
// MMIO responder for timer, LED, 7-segment digits and free-running systick registers.
// Latency: reads are combinational (zero cycles); writes commit at posedge clk.
// Backpressure: none; every in-window access completes in the cycle it is presented.
module mmio_timer_periph
    import mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEFAULT,
    parameter int          LED_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      Address,
    input  logic [31:0]      WriteData,
    input  logic             MemRead,
    input  logic             MemWrite,
    output logic [31:0]      ReadData,
    output logic             sel,
    output logic [LED_W-1:0] led,
    output logic [11:0]      digits,
    output logic             irq
);

    logic [2:0]  off;
    logic        wr;
    logic [31:0] th;
    logic [31:0] tl;
    logic [2:0]  tcon;
    logic [31:0] systick;
    logic        unused_addr_lsb;

    // byte lane bits play no part: only word accesses exist
    assign unused_addr_lsb = ^Address[1:0];

    // Window decode: upper bits match the base and offset names a real register
    assign off = Address[4:2];
    assign sel = (Address[31:5] == BASE_ADDR[31:5]) && (off <= OFF_SYSTICK);
    assign wr  = MemWrite && sel;

    timer_core u_timer_core (
        .clk     (clk),
        .reset   (reset),
        .we_th   (wr && (off == OFF_TH)),
        .we_tl   (wr && (off == OFF_TL)),
        .we_tcon (wr && (off == OFF_TCON)),
        .wdata   (WriteData),
        .th      (th),
        .tl      (tl),
        .tcon    (tcon)
    );

    assign irq = tcon[TCON_IRQ];

    // LED and digit registers, written from the bus
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            led    <= '0;
            digits <= DIGITS_RESET;
        end else if (wr) begin
            if (off == OFF_LED) begin
                led <= WriteData[LED_W-1:0];
            end
            if (off == OFF_DIGITS) begin
                digits <= WriteData[11:0];
            end
        end
    end

    // Free-running systick; bus writes never touch it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            systick <= 32'h0;
        end else begin
            systick <= systick + 32'd1;
        end
    end

    // Read mux: zero unless a load hits the window
    always_comb begin
        ReadData = 32'h0;
        if (MemRead && sel) begin
            case (off)
                OFF_TH:      ReadData = th;
                OFF_TL:      ReadData = tl;
                OFF_TCON:    ReadData = {29'h0, tcon};
                OFF_LED:     ReadData = 32'(led);
                OFF_DIGITS:  ReadData = {20'h0, digits};
                OFF_SYSTICK: ReadData = systick;
                default:     ReadData = 32'h0;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_timer_periph.sv
// Directed self-checking bench for mmio_timer_periph.
// Inputs change on negedge; outputs are sampled at negedge or just after input changes.
// Expected values are hand-computed constants.
module tb_mmio_timer_periph;

    localparam logic [31:0] A_TH   = 32'h4000_0000;
    localparam logic [31:0] A_TL   = 32'h4000_0004;
    localparam logic [31:0] A_TCON = 32'h4000_0008;
    localparam logic [31:0] A_LED  = 32'h4000_000C;
    localparam logic [31:0] A_DIG  = 32'h4000_0010;
    localparam logic [31:0] A_TICK = 32'h4000_0014;
    localparam logic [31:0] A_OUT  = 32'h4000_0018;

    logic        clk;
    logic        reset;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] ReadData;
    logic        sel;
    logic [15:0] led;
    logic [11:0] digits;
    logic        irq;

    int total = 0;
    int bad   = 0;

    mmio_timer_periph #(
        .BASE_ADDR (32'h4000_0000),
        .LED_W     (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .Address   (Address),
        .WriteData (WriteData),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .ReadData  (ReadData),
        .sel       (sel),
        .led       (led),
        .digits    (digits),
        .irq       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    // Store: presented from a negedge, commits at the next posedge, returns at the following negedge
    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        Address   = addr;
        WriteData = data;
        MemWrite  = 1'b1;
        @(negedge clk);
        MemWrite  = 1'b0;
    endtask

    // Load: combinational, consumes no clock
    task automatic rd(input logic [31:0] addr, output logic [31:0] data);
        Address = addr;
        MemRead = 1'b1;
        #1;
        data    = ReadData;
        MemRead = 1'b0;
    endtask

    logic [31:0] v;
    logic [31:0] t0;
    logic [31:0] t1;

    initial begin
        reset     = 1'b0;
        Address   = 32'h0;
        WriteData = 32'h0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        repeat (2) @(negedge clk);

        // Reset values while reset is held
        chk("rst_led", 32'(led), 32'h0);
        chk("rst_digits", 32'(digits), 32'h0000_0F00);
        chk("rst_irq", 32'(irq), 32'h0);
        reset = 1'b1;
        @(negedge clk);
        rd(A_TCON, v);
        chk("rst_tcon_rd", v, 32'h0);

        // Out-of-window address
        Address = A_OUT;
        MemRead = 1'b1;
        #1;
        chk("oow_sel", 32'(sel), 32'h0);
        chk("oow_rdata", ReadData, 32'h0);
        MemRead = 1'b0;
        Address = A_LED;
        #1;
        chk("noread_rdata", ReadData, 32'h0);
        @(negedge clk);

        // LED / digits
        wr(A_LED, 32'h1234_ABCD);
        chk("led_out", 32'(led), 32'h0000_ABCD);
        rd(A_LED, v);
        chk("led_rd", v, 32'h0000_ABCD);
        wr(A_DIG, 32'hFFFF_F7C0);
        chk("digits_out", 32'(digits), 32'h0000_07C0);
        wr(A_OUT, 32'h0000_5555);
        chk("oow_write_led", 32'(led), 32'h0000_ABCD);

        // Read in the same cycle as a write returns the old value
        Address   = A_LED;
        WriteData = 32'h0000_0011;
        MemWrite  = 1'b1;
        MemRead   = 1'b1;
        #1;
        chk("rw_same_cycle", ReadData, 32'h0000_ABCD);
        @(negedge clk);
        MemWrite = 1'b0;
        MemRead  = 1'b0;
        chk("rw_after", 32'(led), 32'h0000_0011);

        // Systick
        rd(A_TICK, t0);
        repeat (5) @(negedge clk);
        rd(A_TICK, t1);
        chk("systick_delta5", t1 - t0, 32'd5);
        rd(A_TICK, t0);
        wr(A_TICK, 32'h0);
        rd(A_TICK, t1);
        chk("systick_wr_ignored", t1 - t0, 32'd1);

        // Timer reload and irq
        wr(A_TH, 32'hFFFF_FFFD);
        wr(A_TL, 32'hFFFF_FFFE);
        wr(A_TCON, 32'h0000_0003);
        rd(A_TL, v);
        chk("tl_at_enable", v, 32'hFFFF_FFFE);
        @(negedge clk);
        rd(A_TL, v);
        chk("tl_max", v, 32'hFFFF_FFFF);
        @(negedge clk);
        rd(A_TL, v);
        chk("tl_reload", v, 32'hFFFF_FFFD);
        chk("irq_set", 32'(irq), 32'h1);
        @(negedge clk);
        rd(A_TL, v);
        chk("tl_after_reload", v, 32'hFFFF_FFFE);
        chk("irq_sticky", 32'(irq), 32'h1);

        // Software clear, counting continues
        wr(A_TCON, 32'h0000_0003);
        chk("irq_cleared", 32'(irq), 32'h0);
        rd(A_TL, v);
        chk("tl_counting", v, 32'hFFFF_FFFF);

        // Clear on the exact overflow cycle: written value wins
        wr(A_TCON, 32'h0000_0003);
        chk("irq_clear_on_ovf", 32'(irq), 32'h0);
        rd(A_TL, v);
        chk("tl_reload2", v, 32'hFFFF_FFFD);
        rd(A_TCON, v);
        chk("tcon_rd", v, 32'h0000_0003);

        // TL write on the overflow cycle: write wins, no reload
        @(negedge clk);
        @(negedge clk);
        wr(A_TL, 32'h0000_0005);
        rd(A_TL, v);
        chk("tl_write_on_ovf", v, 32'h0000_0005);

        // TCON keeps only bits [2:0]
        wr(A_TCON, 32'hFFFF_FFF8);
        rd(A_TCON, v);
        chk("tcon_mask", v, 32'h0);
        rd(A_TL, v);
        t0 = v;
        @(negedge clk);
        rd(A_TL, v);
        chk("tl_idle_hold", v, t0);

        // Mid-count reset
        wr(A_TCON, 32'h0000_0007);
        wr(A_TL, 32'h0000_0100);
        chk("irq_forced", 32'(irq), 32'h1);
        @(negedge clk);
        rd(A_TL, v);
        chk("tl_pre_reset", v, 32'h0000_0101);
        reset = 1'b0;
        #1;
        rd(A_TL, v);
        chk("tl_in_reset", v, 32'h0);
        chk("irq_in_reset", 32'(irq), 32'h0);
        chk("led_in_reset", 32'(led), 32'h0);
        chk("digits_in_reset", 32'(digits), 32'h0000_0F00);
        @(negedge clk);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        rd(A_TL, v);
        chk("tl_after_release", v, 32'h0);
        rd(A_TICK, v);
        chk("systick_after_release", v, 32'd10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
